// File: rtl/spectrum_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// spectrum_display_ctrl_if
//   Bundles the FFT writer handshake and the single-port spectrum RAM bus
//   that spectrum_display_ctrl arbitrates.
//
//   Handshake: the writer raises i_wr_req with i_wr_addr/i_wr_data stable and
//   keeps all three held until a cycle where o_wr_ready is also high; that
//   cycle (i_wr_req & o_wr_ready) is the one and only transfer. o_wr_ready
//   does not depend on i_wr_req.
//
//   Signals (direction as seen by the controller):
//     i_wr_req     writer has a bin to store
//     i_wr_addr    bin index
//     i_wr_data    magnitude
//     o_wr_ready   write accepted this cycle when i_wr_req & o_wr_ready
//     o_ram_addr   RAM address
//     o_ram_we     RAM write strobe
//     o_ram_wdata  RAM write data
//     i_ram_rdata  RAM read data, one cycle after the address
//
//   Modports: slave = controller side, master = writer/RAM side.
// ---------------------------------------------------------------------------
interface spectrum_display_ctrl_if #(
   parameter int DATA_W = 9,
   parameter int ADDR_W = 6
);
   logic              i_wr_req;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_ready;
   logic [ADDR_W-1:0] o_ram_addr;
   logic              o_ram_we;
   logic [DATA_W-1:0] o_ram_wdata;
   logic [DATA_W-1:0] i_ram_rdata;

   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data, i_ram_rdata,
      output o_wr_ready, o_ram_addr, o_ram_we, o_ram_wdata
   );

   modport master (
      output i_wr_req, i_wr_addr, i_wr_data, i_ram_rdata,
      input  o_wr_ready, o_ram_addr, o_ram_we, o_ram_wdata
   );
endinterface

// File: rtl/spectrum_display_ctrl.sv
// ---------------------------------------------------------------------------
// spectrum_display_ctrl
//   Shares one single-port spectrum RAM (one magnitude word per FFT bin)
//   between the FFT result writer and the VGA raster. Active video owns the
//   port and reads one bin per group of 2**BIN_SHIFT columns; the writer only
//   gets the port in blanking. The bar decision is pipelined two cycles and
//   the syncs are delayed to stay aligned with it.
//
//   Optional build macro SPECTRUM_VBLANK_ONLY_EN: when defined, writes are
//   accepted in vertical blanking only, so each frame shows one coherent
//   spectrum. When undefined, horizontal and vertical blanking both accept
//   writes.
//
//   Ports:
//     i_clk           pixel clock
//     i_rst           synchronous, active-high reset
//     i_active_video  raster is in the active area
//     i_x_pos         column (0 outside active)
//     i_y_pos         row (0 outside active)
//     i_hsync/i_vsync syncs from the generator, active low
//     bus             writer handshake + RAM port (slave modport)
//     o_pixel_on      bar pixel lit, 2 cycles after the raster inputs
//     o_hsync/o_vsync syncs delayed 2 cycles to match o_pixel_on
//     o_frame_done    1-cycle pulse when the frame ends (entry to S_VBLANK)
//     o_dbg_state     current FSM state (0 = S_VBLANK, 1 = S_FRAME)
// ---------------------------------------------------------------------------
module spectrum_display_ctrl #(
   parameter int DATA_W    = 9,
   parameter int ADDR_W    = 6,
   parameter int BIN_SHIFT = 3,
   parameter int V_ACTIVE  = 480
) (
   input  logic  i_clk,
   input  logic  i_rst,
   input  logic  i_active_video,
   input  logic [9:0] i_x_pos,
   input  logic [8:0] i_y_pos,
   input  logic  i_hsync,
   input  logic  i_vsync,
   spectrum_display_ctrl_if.slave bus,
   output logic  o_pixel_on,
   output logic  o_hsync,
   output logic  o_vsync,
   output logic  o_frame_done,
   output logic  o_dbg_state
);

   localparam int XBIN_W = 10 - BIN_SHIFT;
   localparam logic [8:0]      Y_LAST   = 9'(V_ACTIVE - 1);
   localparam logic [DATA_W:0] Y_LAST_W = (DATA_W + 1)'(V_ACTIVE - 1);

   typedef enum logic {
      S_VBLANK = 1'b0,
      S_FRAME  = 1'b1
   } state_t;

   state_t state;

   // Stage 1 registers (aligned with the RAM read data)
   logic              active1;
   logic [8:0]        y1;
   logic              bin_valid1;
   logic              hsync1;
   logic              vsync1;

   // ------------------------------------------------------------------
   // Column -> bin. Columns past the last bin still drive a legal address
   // (clamped to the last bin) but are flagged invalid so they stay dark.
   // ------------------------------------------------------------------
   logic [XBIN_W-1:0] x_bin;
   logic              x_in_range;
   logic [ADDR_W-1:0] disp_addr;

   assign x_bin      = XBIN_W'(i_x_pos >> BIN_SHIFT);
   assign x_in_range = ~|(x_bin >> ADDR_W);
   assign disp_addr  = x_in_range ? ADDR_W'(x_bin) : {ADDR_W{1'b1}};

   // ------------------------------------------------------------------
   // Port ownership. Display has absolute priority; a pending write just
   // sees o_wr_ready low and holds its request until blanking.
   // ------------------------------------------------------------------
   logic wr_ready;

   always_comb begin
      wr_ready = !i_active_video && !i_rst;
`ifdef SPECTRUM_VBLANK_ONLY_EN
      wr_ready = wr_ready && (state == S_VBLANK);
`endif
   end

   assign bus.o_wr_ready  = wr_ready;
   assign bus.o_ram_addr  = i_active_video ? disp_addr : bus.i_wr_addr;
   assign bus.o_ram_we    = bus.i_wr_req && wr_ready;
   assign bus.o_ram_wdata = bus.i_wr_data;

   // ------------------------------------------------------------------
   // Bar decision: row y is lit when the bar reaches it, i.e. the distance
   // from the bottom row (V_ACTIVE-1-y) is below the magnitude. Compared
   // one bit wider so magnitudes >= V_ACTIVE simply light the full column.
   // ------------------------------------------------------------------
   logic [DATA_W:0] rows_above_bottom;
   logic            bar_hit;

   assign rows_above_bottom = Y_LAST_W - (DATA_W + 1)'(y1);
   assign bar_hit           = rows_above_bottom < {1'b0, bus.i_ram_rdata};

   // ------------------------------------------------------------------
   // Pipeline + frame FSM. Frame end is the falling edge of active video
   // on the last active row, seen via the stage-1 copies of active and y.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= S_VBLANK;
         active1      <= 1'b0;
         y1           <= '0;
         bin_valid1   <= 1'b0;
         hsync1       <= 1'b1;
         vsync1       <= 1'b1;
         o_pixel_on   <= 1'b0;
         o_hsync      <= 1'b1;
         o_vsync      <= 1'b1;
         o_frame_done <= 1'b0;
      end else begin
         active1      <= i_active_video;
         y1           <= i_y_pos;
         bin_valid1   <= x_in_range;
         hsync1       <= i_hsync;
         vsync1       <= i_vsync;
         o_pixel_on   <= active1 && bin_valid1 && bar_hit;
         o_hsync      <= hsync1;
         o_vsync      <= vsync1;
         o_frame_done <= 1'b0;

         case (state)
            S_VBLANK: begin
               if (i_active_video && (i_x_pos == 10'd0) && (i_y_pos == 9'd0))
                  state <= S_FRAME;
            end
            S_FRAME: begin
               if (active1 && !i_active_video && (y1 == Y_LAST)) begin
                  state        <= S_VBLANK;
                  o_frame_done <= 1'b1;
               end
            end
            default: state <= S_VBLANK;
         endcase
      end
   end

   assign o_dbg_state = (state == S_FRAME);

endmodule

// File: tb/tb_spectrum_display_ctrl.sv
module tb_spectrum_display_ctrl;

   localparam int DATA_W   = 9;
   localparam int ADDR_W   = 6;
   localparam int N_BINS   = 64;
   localparam int V_ACTIVE = 480;
   localparam int H_BLANK  = 6;
   localparam int V_BLANK  = 10;
   localparam int N_COLS   = 14;

   // ---------------- clock / reset / DUT ----------------
   logic       i_clk = 1'b0;
   logic       i_rst = 1'b1;
   logic       act   = 1'b0;
   logic [9:0] x_pos = '0;
   logic [8:0] y_pos = '0;
   logic       hs_in = 1'b1;
   logic       vs_in = 1'b1;
   logic       o_pixel_on, o_hsync, o_vsync, o_frame_done, o_dbg_state;

   spectrum_display_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   always #5 i_clk = ~i_clk;

   spectrum_display_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BIN_SHIFT(3), .V_ACTIVE(V_ACTIVE)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_active_video (act),
      .i_x_pos        (x_pos),
      .i_y_pos        (y_pos),
      .i_hsync        (hs_in),
      .i_vsync        (vs_in),
      .bus            (bus.slave),
      .o_pixel_on     (o_pixel_on),
      .o_hsync        (o_hsync),
      .o_vsync        (o_vsync),
      .o_frame_done   (o_frame_done),
      .o_dbg_state    (o_dbg_state)
   );

   // Single-port RAM with 1-cycle synchronous read (read returns old data)
   logic [DATA_W-1:0] ram [N_BINS];
   always @(posedge i_clk) begin
      if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
      bus.i_ram_rdata <= ram[bus.o_ram_addr];
   end

   // ---------------- scoreboard / model ----------------
   logic [2:0] exp_q[$];          // {pixel_on, hsync, vsync}
   int         exp_mag [N_BINS];
   logic       m_in_frame, m_prev_act, exp_fd;
   int         m_prev_y;
   int         n_cmp = 0, n_err = 0;
   int         fd_count = 0;

   int cols [N_COLS] = '{0, 7, 8, 39, 40, 47, 48, 100, 503, 504, 511, 512, 600, 639};
   int req_row = -1, rst_row = -1, acc_row = -1;
   logic pend = 1'b0;
   int   pend_addr = 0, pend_data = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // One raster cycle: sample outputs after the edge, then drive new inputs
   task automatic step(input logic s_rst, input logic s_act, input int sx, input int sy,
                       input logic s_hs, input logic s_vs, input logic s_req,
                       input int s_wa, input int s_wd, output logic accepted);
      logic [2:0] e;
      logic       e_ready;
      logic       pix;
      int         bin;
      @(posedge i_clk);
      #1;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         check("pipe_pix_hs_vs", {o_pixel_on, o_hsync, o_vsync}, e);
      end
      check("frame_done", o_frame_done, exp_fd);
      check("fsm_state", o_dbg_state, m_in_frame);
      if (o_frame_done) fd_count++;

      i_rst = s_rst;
      act   = s_act;
      x_pos = 10'(sx);
      y_pos = 9'(sy);
      hs_in = s_hs;
      vs_in = s_vs;
      bus.i_wr_req  = s_req;
      bus.i_wr_addr = ADDR_W'(s_wa);
      bus.i_wr_data = DATA_W'(s_wd);
      #1;

      e_ready = !s_act && !s_rst;
`ifdef SPECTRUM_VBLANK_ONLY_EN
      e_ready = e_ready && !m_in_frame;
`endif
      accepted = s_req && e_ready;
      if (s_req) begin
         check("wr_ready", bus.o_wr_ready, e_ready);
         check("ram_we", bus.o_ram_we, accepted);
      end
      if (accepted) exp_mag[s_wa] = s_wd;

      bin = sx >> 3;
      pix = 1'b0;
      if (s_act && bin < N_BINS) pix = ((V_ACTIVE - 1 - sy) < exp_mag[bin]);

      if (s_rst) begin
         if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = 3'b011;
         exp_q.push_back(3'b011);
         exp_fd     = 1'b0;
         m_in_frame = 1'b0;
         m_prev_act = 1'b0;
         m_prev_y   = 0;
      end else begin
         exp_q.push_back({pix, s_hs, s_vs});
         exp_fd = m_in_frame && m_prev_act && !s_act && (m_prev_y == V_ACTIVE - 1);
         if (exp_fd) m_in_frame = 1'b0;
         else if (!m_in_frame && s_act && sx == 0 && sy == 0) m_in_frame = 1'b1;
         m_prev_act = s_act;
         m_prev_y   = sy;
      end
   endtask

   task automatic run_line(input int row, input logic is_active, input logic vs_lvl);
      logic acc, r;
      for (int c = 0; c < N_COLS; c++) begin
         if (is_active && row == req_row && c == 0) pend = 1'b1;
         r = is_active && (row == rst_row) && (c >= 4) && (c < 7);
         step(r, is_active, is_active ? cols[c] : 0, is_active ? row : 0, 1'b1, vs_lvl,
              pend, pend_addr, pend_data, acc);
         if (acc) begin pend = 1'b0; acc_row = row; end
      end
      for (int b = 0; b < H_BLANK; b++) begin
         step(1'b0, 1'b0, 0, 0, !(b >= 1 && b <= 3), vs_lvl, pend, pend_addr, pend_data, acc);
         if (acc) begin pend = 1'b0; acc_row = row; end
      end
   endtask

   task automatic run_frame();
      for (int row = 0; row < V_ACTIVE; row++) run_line(row, 1'b1, 1'b1);
      for (int v = 0; v < V_BLANK; v++) run_line(-1, 1'b0, !(v >= 2 && v <= 3));
   endtask

   // ---------------- table of port-ownership vectors ----------------
   typedef struct {
      logic act;
      int   x;
      logic req;
      int   addr;
      int   data;
      logic exp_ready;
      logic exp_we;
      int   exp_addr;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic acc;
      for (int i = 0; i < N_BINS; i++) begin ram[i] = '0; exp_mag[i] = 0; end
      bus.i_ram_rdata = '0;
      bus.i_wr_req  = 1'b0;
      bus.i_wr_addr = '0;
      bus.i_wr_data = '0;
      m_in_frame = 1'b0; m_prev_act = 1'b0; m_prev_y = 0; exp_fd = 1'b0;

      //          act   x    req   addr data  ready we    exp_addr
      tbl[0]  = '{1'b0, 0,   1'b1, 5,   100, 1'b1, 1'b1, 5};
      tbl[1]  = '{1'b1, 40,  1'b1, 7,   9,   1'b0, 1'b0, 5};
      tbl[2]  = '{1'b1, 639, 1'b0, 7,   9,   1'b0, 1'b0, 63};
      tbl[3]  = '{1'b1, 511, 1'b1, 2,   3,   1'b0, 1'b0, 63};
      tbl[4]  = '{1'b1, 512, 1'b0, 2,   3,   1'b0, 1'b0, 63};
      tbl[5]  = '{1'b1, 0,   1'b0, 2,   3,   1'b0, 1'b0, 0};
      tbl[6]  = '{1'b0, 0,   1'b0, 9,   1,   1'b1, 1'b0, 9};
      tbl[7]  = '{1'b0, 0,   1'b1, 63,  511, 1'b1, 1'b1, 63};
      tbl[8]  = '{1'b0, 0,   1'b1, 0,   0,   1'b1, 1'b1, 0};
      tbl[9]  = '{1'b1, 8,   1'b0, 0,   0,   1'b0, 1'b0, 1};
      tbl[10] = '{1'b0, 0,   1'b1, 1,   300, 1'b1, 1'b1, 1};
      tbl[11] = '{1'b0, 0,   1'b1, 6,   479, 1'b1, 1'b1, 6};
      tbl[12] = '{1'b0, 0,   1'b1, 4,   480, 1'b1, 1'b1, 4};
      tbl[13] = '{1'b0, 0,   1'b1, 12,  1,   1'b1, 1'b1, 12};

      // Reset with a write request held: nothing may be granted
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 5, 77, acc);
      check("rst_pixel_on", o_pixel_on, 1'b0);
      check("rst_frame_done", o_frame_done, 1'b0);
      check("rst_hsync", o_hsync, 1'b1);
      check("rst_vsync", o_vsync, 1'b1);
      check("rst_state", o_dbg_state, 1'b0);
      check("rst_wr_ready", bus.o_wr_ready, 1'b0);
      check("rst_ram_we", bus.o_ram_we, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, acc);

      // Table: ownership / address mux, also loads the spectrum
      for (int i = 0; i < 14; i++) begin
         step(1'b0, tbl[i].act, tbl[i].x, 5, 1'b1, 1'b1, tbl[i].req, tbl[i].addr, tbl[i].data, acc);
         check($sformatf("tbl%0d_ready", i), bus.o_wr_ready, tbl[i].exp_ready);
         check($sformatf("tbl%0d_we", i), bus.o_ram_we, tbl[i].exp_we);
         check($sformatf("tbl%0d_addr", i), bus.o_ram_addr, tbl[i].exp_addr);
         if (tbl[i].exp_we) check($sformatf("tbl%0d_wdata", i), bus.o_ram_wdata, tbl[i].data);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, acc);

      // Frame A: plain display of the loaded bars
      run_frame();

      // Frame B: write request raised at the start of row 100, held until granted
      req_row = 100; pend_addr = 12; pend_data = 50; acc_row = -1;
      run_frame();
      req_row = -1;
      check("write_pending_after_frame", pend, 1'b0);
`ifdef SPECTRUM_VBLANK_ONLY_EN
      check("write_accept_row", acc_row, V_ACTIVE - 1);
`else
      check("write_accept_row", acc_row, 100);
`endif

      // Frame C: reset for 3 cycles on row 200, no frame_done this frame
      rst_row = 200;
      run_frame();
      rst_row = -1;

      // Frame D: display must be correct again
      run_frame();

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 0, 0, acc);
      check("frame_done_count", fd_count, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
